// File: rtl/mem_pkg.sv
// Shared constants for the memory access unit: funct3 width/sign encodings,
// FSM state encoding, byte-enable patterns and small decode helpers.
package mem_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Byte-enable patterns before shifting into the addressed lane
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    SIZE_B,
    SIZE_H,
    SIZE_W
  } access_size_t;

  // Access width from funct3; unsigned variants share the signed width and
  // any reserved encoding behaves as a full word.
  function automatic access_size_t decodeSize(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: decodeSize = SIZE_B;
      F3_H, F3_HU: decodeSize = SIZE_H;
      default:     decodeSize = SIZE_W;
    endcase
  endfunction

  // Lane enables for an access of the given size at the given byte offset;
  // halfwords ignore offset bit 0 so they always land on a halfword lane.
  function automatic logic [3:0] byteEnable(input access_size_t size, input logic [1:0] offset);
    case (size)
      SIZE_B:  byteEnable = BE_BYTE << offset;
      SIZE_H:  byteEnable = BE_HALF << {offset[1], 1'b0};
      default: byteEnable = BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane selection and sign/zero extension. Picks the addressed byte or
// halfword out of the bus read word and extends it according to funct3.
module load_extend #(
  parameter int WORD_BITWIDTH = 32
) (
  input  logic [WORD_BITWIDTH-1:0] rdata,
  input  logic [2:0]               funct3,
  input  logic [1:0]               offset,
  output logic [WORD_BITWIDTH-1:0] data
);

  import mem_pkg::*;

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  assign laneByte = rdata[{offset, 3'b000} +: 8];
  assign laneHalf = rdata[{offset[1], 4'b0000} +: 16];

  // Extend the selected lane; words and reserved encodings pass straight through
  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{(WORD_BITWIDTH-8){laneByte[7]}}, laneByte};
      F3_BU:   data = {{(WORD_BITWIDTH-8){1'b0}}, laneByte};
      F3_H:    data = {{(WORD_BITWIDTH-16){laneHalf[15]}}, laneHalf};
      F3_HU:   data = {{(WORD_BITWIDTH-16){1'b0}}, laneHalf};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns MEM-stage load/store requests into a single
// outstanding bus transaction (IDLE -> REQ -> DONE), stalls the pipeline while
// the bus is busy, extends load data and flags bus timeouts.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, misaligned halfword
// and word accesses trap with accessErr instead of being issued to the bus.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WORD_BITWIDTH-1:0] address,
  input  logic [WORD_BITWIDTH-1:0] memWriteData,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [2:0]               funct3,
  output logic                     busReq,
  output logic                     busWe,
  output logic [WORD_BITWIDTH-1:0] busAddr,
  output logic [WORD_BITWIDTH-1:0] busWdata,
  output logic [3:0]               busByteEn,
  input  logic                     busAck,
  input  logic [WORD_BITWIDTH-1:0] busRdata,
  output logic [WORD_BITWIDTH-1:0] loadData,
  output logic                     loadValid,
  output logic                     stall,
  output logic                     accessErr
);

  localparam int TIMER_BITS = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(ACK_TIMEOUT - 1);

  logic [1:0]               state;
  logic [TIMER_BITS-1:0]    timer;
  logic [2:0]               reqFunct3;
  logic [1:0]               reqOffset;
  logic [WORD_BITWIDTH-1:0] extData;
  logic [WORD_BITWIDTH-1:0] replicatedData;
  logic                     request;
  logic                     misaligned;
  access_size_t             reqSize;

  assign request = memRead | memWrite;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((reqSize == SIZE_H) && address[0]) ||
                      ((reqSize == SIZE_W) && (address[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Decode the access width and replicate store data across every lane it may hit
  always_comb begin
    reqSize = decodeSize(funct3);
    case (reqSize)
      SIZE_B:  replicatedData = {(WORD_BITWIDTH/8){memWriteData[7:0]}};
      SIZE_H:  replicatedData = {(WORD_BITWIDTH/16){memWriteData[15:0]}};
      default: replicatedData = memWriteData;
    endcase
  end

  // Hold the pipeline while a request waits to launch or is on the bus; an
  // error pulse releases it so the faulting instruction can move on
  always_comb begin
    stall = rst_n & (((state == IDLE) && request && !accessErr) || (state == REQ));
  end

  load_extend #(
    .WORD_BITWIDTH(WORD_BITWIDTH)
  ) u_load_extend (
    .rdata  (busRdata),
    .funct3 (reqFunct3),
    .offset (reqOffset),
    .data   (extData)
  );

  // Request FSM: launch in IDLE, wait for busAck or timeout in REQ, one DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      busReq    <= 1'b0;
      busWe     <= 1'b0;
      busAddr   <= '0;
      busWdata  <= '0;
      busByteEn <= 4'b0000;
      reqFunct3 <= 3'b000;
      reqOffset <= 2'b00;
      loadData  <= '0;
      loadValid <= 1'b0;
      accessErr <= 1'b0;
    end else begin
      accessErr <= 1'b0;
      loadValid <= 1'b0;
      case (state)
        IDLE: begin
          if (request && !accessErr) begin
            if (misaligned) begin
              accessErr <= 1'b1;
            end else begin
              state     <= REQ;
              timer     <= '0;
              busReq    <= 1'b1;
              busWe     <= memWrite & ~memRead;
              busAddr   <= {address[WORD_BITWIDTH-1:2], 2'b00};
              busWdata  <= replicatedData;
              busByteEn <= byteEnable(reqSize, address[1:0]);
              reqFunct3 <= funct3;
              reqOffset <= address[1:0];
            end
          end
        end
        REQ: begin
          if (busAck) begin
            state  <= DONE;
            timer  <= '0;
            busReq <= 1'b0;
            if (!busWe) begin
              loadData  <= extData;
              loadValid <= 1'b1;
            end
          end else if (timer == TIMER_LAST) begin
            state     <= IDLE;
            timer     <= '0;
            busReq    <= 1'b0;
            accessErr <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
